// File: rtl/ps2_receiver.sv
`timescale 1ns/1ps
// PS/2 device-to-host receiver: synchronizes and deglitches PS2_CLK, decodes
// 11-bit frames and keeps the two most recent scan bytes in KBBuffer.
module ps2_receiver #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    output logic [15:0] KBBuffer,
    output logic        New_Code,
    output logic        Parity_Err,
    output logic        Frame_Err,
    output logic        Busy
);

    localparam int unsigned FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    logic [1:0]        clk_sync_q;
    logic [1:0]        dat_sync_q;
    logic              clk_s;
    logic              dat_s;
    logic              filt_q;
    logic              filt_d;
    logic [FCNT_W-1:0] fcnt_q;
    logic [FCNT_W-1:0] fcnt_d;
    logic              fall_c;
    logic              timeout_c;

    state_e            state_q;
    logic              busy_q;
    logic [2:0]        bitcnt_q;
    logic [7:0]        shift_q;
    logic              par_q;
    logic [TCNT_W-1:0] tcnt_q;
    logic [15:0]       kbbuf_q;
    logic              new_q;
    logic              perr_q;
    logic              ferr_q;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];

    // Two-flop synchronizers and clock filter state; idle line level is high.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[0], PS2_DATA};
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
        end
    end

    // The filtered clock follows only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        fall_c = 1'b0;
        if (clk_s != filt_q) begin
            if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
                fall_c = filt_q;
            end else begin
                fcnt_d = fcnt_q + FCNT_W'(1);
            end
        end
    end

    assign timeout_c = busy_q && (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));

    // Frame decoder; a timeout wins over an edge detected in the same cycle.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tcnt_q   <= '0;
            kbbuf_q  <= '0;
            new_q    <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            new_q  <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            if (busy_q) begin
                tcnt_q <= tcnt_q + TCNT_W'(1);
            end else begin
                tcnt_q <= '0;
            end

            if (timeout_c) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                tcnt_q  <= '0;
                ferr_q  <= 1'b1;
            end else if (fall_c) begin
                tcnt_q <= '0;
                case (state_q)
                    S_IDLE: begin
                        if (!dat_s) begin
                            state_q  <= S_DATA;
                            busy_q   <= 1'b1;
                            bitcnt_q <= '0;
                            shift_q  <= '0;
                        end
                    end
                    S_DATA: begin
                        shift_q  <= {dat_s, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            state_q <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        par_q   <= dat_s;
                        state_q <= S_STOP;
                    end
                    S_STOP: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        if (!dat_s) begin
                            ferr_q <= 1'b1;
                        end else if (!(^{shift_q, par_q})) begin
                            perr_q <= 1'b1;
                        end else begin
                            kbbuf_q <= {kbbuf_q[7:0], shift_q};
                            new_q   <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign KBBuffer   = kbbuf_q;
    assign New_Code   = new_q;
    assign Parity_Err = perr_q;
    assign Frame_Err  = ferr_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_ps2_receiver.sv
`timescale 1ns/1ps
// Self-checking bench for ps2_receiver: table of frames, multi-cycle corner
// sequences, then random frames against a frame-level reference model.
module tb_ps2_receiver;

    localparam int FILT = 8;
    localparam int TMO  = 200;
    localparam int K_NEW  = 0;
    localparam int K_PERR = 1;
    localparam int K_FERR = 2;

    typedef struct {
        logic [7:0]  data;
        logic        par;
        logic        stop;
        logic [15:0] kb;
        int          kind;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        PS2_CLK;
    logic        PS2_DATA;
    logic [15:0] KBBuffer;
    logic        New_Code;
    logic        Parity_Err;
    logic        Frame_Err;
    logic        Busy;

    ps2_receiver #(
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .PS2_CLK    (PS2_CLK),
        .PS2_DATA   (PS2_DATA),
        .KBBuffer   (KBBuffer),
        .New_Code   (New_Code),
        .Parity_Err (Parity_Err),
        .Frame_Err  (Frame_Err),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling CLK edge.
    int   n_new = 0, n_perr = 0, n_ferr = 0;
    int   last_pulse_cyc = 0, mutex_bad = 0, long_bad = 0;
    logic prev_new = 1'b0, prev_perr = 1'b0, prev_ferr = 1'b0;
    always @(negedge CLK) begin
        if (New_Code === 1'b1)   begin n_new++;  last_pulse_cyc = cyc; end
        if (Parity_Err === 1'b1) begin n_perr++; last_pulse_cyc = cyc; end
        if (Frame_Err === 1'b1)  begin n_ferr++; last_pulse_cyc = cyc; end
        if (int'(New_Code === 1'b1) + int'(Parity_Err === 1'b1) + int'(Frame_Err === 1'b1) > 1)
            mutex_bad++;
        if ((New_Code === 1'b1 && prev_new) || (Parity_Err === 1'b1 && prev_perr) ||
            (Frame_Err === 1'b1 && prev_ferr))
            long_bad++;
        prev_new  = (New_Code === 1'b1);
        prev_perr = (Parity_Err === 1'b1);
        prev_ferr = (Frame_Err === 1'b1);
    end

    int checks = 0;
    int errors = 0;
    int last_fall = 0;

    // Reference model state: expected buffer and cumulative pulse counts.
    logic [15:0] exp_buf = 16'h0000;
    int          exp_new = 0, exp_perr = 0, exp_ferr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_frame(input logic [7:0] b, input logic par,
                                        input logic stop, input int nedges);
        if (nedges < 11)                         exp_ferr++;
        else if (!stop)                          exp_ferr++;
        else if ($countones({b, par}) % 2 == 0)  exp_perr++;
        else begin
            exp_buf = {exp_buf[7:0], b};
            exp_new++;
        end
    endfunction

    task automatic check_state(input string tag, input int lat_exp);
        check({tag, ".kb"},   32'(KBBuffer), 32'(exp_buf));
        check({tag, ".new"},  n_new,  exp_new);
        check({tag, ".perr"}, n_perr, exp_perr);
        check({tag, ".ferr"}, n_ferr, exp_ferr);
        check({tag, ".busy"}, 32'(Busy), 32'd0);
        if (lat_exp >= 0)
            check({tag, ".lat"}, last_pulse_cyc - last_fall, lat_exp);
    endtask

    // One keyboard clock period: data set while high, then a low phase.
    task automatic ps2_edge(input logic d, input int hi, input int lo);
        PS2_DATA = d;
        repeat (hi) @(posedge CLK);
        #1;
        PS2_CLK   = 1'b0;
        last_fall = cyc;
        repeat (lo) @(posedge CLK);
        #1;
        PS2_CLK = 1'b1;
    endtask

    task automatic glitch(input int n);
        PS2_CLK = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
        PS2_CLK = 1'b1;
        repeat (12) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                              input int nedges, input int glitch_at, input int hi, input int lo);
        logic [10:0] bits;
        bits = {stop, par, b, 1'b0};
        for (int i = 0; i < nedges; i++) begin
            if (i == glitch_at) begin
                PS2_DATA = bits[i];
                repeat (4) @(posedge CLK);
                #1;
                glitch(3);
            end
            ps2_edge(bits[i], hi, lo);
        end
        PS2_DATA = 1'b1;
        repeat (hi) @(posedge CLK);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [10];
        logic [7:0]  rb;
        logic        rpar, rstop;
        int          rn, hi, lo, base;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 16'h001C, K_NEW};
        vecs[1] = '{8'hF0, 1'b1, 1'b1, 16'h1CF0, K_NEW};
        vecs[2] = '{8'h5A, 1'b0, 1'b1, 16'h1CF0, K_PERR};
        vecs[3] = '{8'h1C, 1'b0, 1'b0, 16'h1CF0, K_FERR};
        vecs[4] = '{8'hE0, 1'b0, 1'b1, 16'hF0E0, K_NEW};
        vecs[5] = '{8'hE0, 1'b0, 1'b1, 16'hE0E0, K_NEW};
        vecs[6] = '{8'h00, 1'b1, 1'b1, 16'hE000, K_NEW};
        vecs[7] = '{8'hFF, 1'b1, 1'b1, 16'h00FF, K_NEW};
        vecs[8] = '{8'hFF, 1'b0, 1'b0, 16'h00FF, K_FERR};
        vecs[9] = '{8'h83, 1'b1, 1'b1, 16'h00FF, K_PERR};

        RESET    = 1'b0;
        PS2_CLK  = 1'b1;
        PS2_DATA = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        check("reset.kb",   32'(KBBuffer),   32'd0);
        check("reset.new",  32'(New_Code),   32'd0);
        check("reset.perr", 32'(Parity_Err), 32'd0);
        check("reset.ferr", 32'(Frame_Err),  32'd0);
        check("reset.busy", 32'(Busy),       32'd0);
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;

        for (int i = 0; i < 10; i++) begin
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, 11, -1, 16 + i, 14 + i);
            repeat (4) @(posedge CLK);
            #1;
            case (vecs[i].kind)
                K_NEW:   exp_new++;
                K_PERR:  exp_perr++;
                default: exp_ferr++;
            endcase
            exp_buf = vecs[i].kb;
            check_state($sformatf("vec%0d", i), FILT + 2);
        end

        // Idle edge with data high is not a start bit.
        ps2_edge(1'b1, 20, 20);
        repeat (20) @(posedge CLK);
        #1;
        check_state("idle_data1", -1);

        // Short low pulses on PS2_CLK, including one cycle under the filter length.
        PS2_DATA = 1'b0;
        glitch(3);
        check("glitch3.busy", 32'(Busy), 32'd0);
        glitch(FILT - 1);
        check("glitch7.busy", 32'(Busy), 32'd0);
        PS2_DATA = 1'b1;
        send_frame(8'h16, 1'b0, 1'b1, 11, 4, 20, 20);
        model_frame(8'h16, 1'b0, 1'b1, 11);
        check_state("glitch_frame", FILT + 2);
        check("glitch_frame.low", 32'(KBBuffer[7:0]), 32'h16);

        // Start plus four data bits then silence: timeout frame error.
        send_frame(8'h3C, 1'b0, 1'b1, 5, -1, 20, 20);
        base = n_ferr;
        for (int t = 0; t < 2 * TMO && n_ferr == base; t++) begin
            @(posedge CLK);
            #1;
        end
        model_frame(8'h3C, 1'b0, 1'b1, 5);
        repeat (20) @(posedge CLK);
        #1;
        check_state("timeout", FILT + 2 + TMO);
        send_frame(8'h45, 1'b0, 1'b1, 11, -1, 20, 20);
        model_frame(8'h45, 1'b0, 1'b1, 11);
        check_state("after_timeout", FILT + 2);
        check("after_timeout.low", 32'(KBBuffer[7:0]), 32'h45);

        // Reset in the middle of a frame, after the fifth data bit.
        send_frame(8'hA5, 1'b1, 1'b1, 6, -1, 20, 20);
        check("rst.busy_before", 32'(Busy), 32'd1);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        check("rst.kb",   32'(KBBuffer), 32'd0);
        check("rst.busy", 32'(Busy),     32'd0);
        RESET   = 1'b1;
        exp_buf = 16'h0000;
        repeat (5) @(posedge CLK);
        #1;
        send_frame(8'h76, 1'b0, 1'b1, 11, -1, 20, 20);
        model_frame(8'h76, 1'b0, 1'b1, 11);
        check_state("after_rst", FILT + 2);
        check("after_rst.kb", 32'(KBBuffer), 32'h0076);

        // Random frames: bad parity, bad stop and truncation mixed in.
        for (int f = 0; f < 40; f++) begin
            rb    = 8'($urandom);
            rpar  = (~^rb) ^ ($urandom_range(0, 99) < 15);
            rstop = ($urandom_range(0, 99) >= 10);
            rn    = ($urandom_range(0, 99) < 10) ? int'($urandom_range(1, 10)) : 11;
            hi    = int'($urandom_range(12, 30));
            lo    = int'($urandom_range(12, 30));
            send_frame(rb, rpar, rstop, rn, -1, hi, lo);
            if (rn < 11) repeat (TMO + 40) @(posedge CLK);
            else         repeat (4) @(posedge CLK);
            #1;
            model_frame(rb, rpar, rstop, rn);
            check_state($sformatf("rand%0d", f), (rn < 11) ? FILT + 2 + TMO : FILT + 2);
        end

        check("pulse_exclusive", mutex_bad, 0);
        check("pulse_width",     long_bad,  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 8, meaning the number of consecutive CLK cycles a synchronized PS2_CLK level must hold before the filtered clock takes that level.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the maximum number of CLK cycles allowed between filtered PS2_CLK falling edges within one frame.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port PS2_CLK, input, 1 bit: raw keyboard clock, asynchronous to CLK.
REQ-006 The block SHALL have port PS2_DATA, input, 1 bit: raw keyboard data, asynchronous to CLK.
REQ-007 The block SHALL have port KBBuffer, output, 16 bits: {previous scan byte, newest scan byte}; it feeds the keyboard controller stage directly.
REQ-008 The block SHALL have port New_Code, output, 1 bit: one-cycle pulse when KBBuffer is updated.
REQ-009 The block SHALL have port Parity_Err, output, 1 bit: one-cycle pulse when a received frame fails odd parity.
REQ-010 The block SHALL have port Frame_Err, output, 1 bit: one-cycle pulse on a bad stop bit or an inter-edge timeout.
REQ-011 The block SHALL have port Busy, output, 1 bit: high while the FSM is in any state other than IDLE.

Function
REQ-012 The block SHALL pass PS2_CLK and PS2_DATA through two-flop synchronizers before any use.
REQ-013 The filter SHALL update the filtered clock only after the synchronized PS2_CLK has differed from it for FILTER_LEN consecutive cycles; any shorter pulse is ignored.
REQ-014 The block SHALL detect a falling edge when the filtered clock goes 1->0, and SHALL sample synchronized PS2_DATA in that same cycle.
REQ-015 The FSM SHALL have states IDLE, DATA, PARITY and STOP.
REQ-016 In IDLE, an edge with data 0 (start bit) SHALL move the FSM to DATA and clear the bit counter and shift register; an edge with data 1 SHALL leave it in IDLE with no flags.
REQ-017 In DATA, each edge SHALL shift in one bit LSB-first; after the 8th bit the FSM SHALL move to PARITY.
REQ-018 In PARITY, the edge SHALL capture the parity bit and then move the FSM to STOP.
REQ-019 A frame is good when the 8 data bits plus the parity bit contain an odd number of ones.
REQ-020 In STOP, the edge SHALL return the FSM to IDLE and resolve the frame in this priority order:
- stop bit 0 -> Frame_Err pulse;
- else parity bad -> Parity_Err pulse;
- else KBBuffer <= {KBBuffer[7:0], byte} and New_Code pulse.
REQ-021 The KBBuffer update and the New_Code or error pulse SHALL appear in the cycle after the stop-bit edge is detected (1-cycle latency).
REQ-022 A frame with any error SHALL leave KBBuffer unchanged.
REQ-023 A timeout counter SHALL clear on every detected edge and on entry to IDLE, and SHALL count every cycle while Busy.
REQ-024 When the timeout counter reaches TIMEOUT_CYCLES, the FSM SHALL return to IDLE, Frame_Err SHALL pulse once, and partial data SHALL be discarded.
REQ-025 The timeout counter SHALL be wide enough for TIMEOUT_CYCLES without wrap.
REQ-026 The timeout SHALL take priority over an edge detected in the same cycle.
REQ-027 All bytes, including 0xE0 and 0xF0, SHALL be shifted into KBBuffer unmodified; a repeated identical byte SHALL still produce New_Code.
REQ-028 At most one of New_Code, Parity_Err and Frame_Err SHALL be high in any cycle.
REQ-029 There is no host-to-device transmit; PS2_CLK and PS2_DATA are inputs only.

Reset
REQ-030 With RESET=0 at a rising edge of CLK, the following SHALL be forced, abandoning any frame in progress:
- FSM to IDLE;
- KBBuffer to 0x0000;
- New_Code, Parity_Err, Frame_Err and Busy to 0;
- counters, shift register and filter state cleared;
- filtered clock and synchronizers set to 1.
REQ-031 After RESET returns to 1, the first falling edge SHALL be treated as a possible start bit.

Verification
REQ-032 Frame 0x1C (parity 0, stop 1) from reset -> KBBuffer=0x001C and one New_Code pulse; then frame 0xF0 (parity 1) -> KBBuffer=0x1CF0.
REQ-033 Frame 0x5A sent with parity bit 0 -> one Parity_Err pulse, KBBuffer unchanged, Busy=0 afterwards.
REQ-034 Frame 0x1C with stop bit 0 -> one Frame_Err pulse, no New_Code, KBBuffer unchanged.
REQ-035 Start bit plus 4 data bits, then PS2_CLK held high (TIMEOUT_CYCLES=200) -> Frame_Err pulse exactly 200 cycles after the last edge, FSM in IDLE; a following frame 0x45 -> KBBuffer low byte 0x45.
REQ-036 A 3-cycle low glitch on PS2_CLK (FILTER_LEN=8) in IDLE and mid-frame -> no bit consumed, and frame 0x16 still decodes correctly.
REQ-037 RESET=0 asserted after the 5th data bit of a frame -> KBBuffer=0x0000 and Busy=0 on the next cycle; the following full frame 0x76 -> KBBuffer=0x0076.
